// File: rtl/pipelined_carry_select_adder.sv
// ---------------------------------------------------------------------------
// pipelined_carry_select_adder
//
// Pipelined carry-select adder: sum = a + b + cin (mod 2^WIDTH).
// The operands are cut into NBLK = WIDTH/BLK blocks. Stage k adds block k
// twice (carry-in 0 and carry-in 1) and picks one result with the carry
// registered by stage k-1, so each stage is a BLK-bit add plus a 2:1 mux.
// One add enters per clock; a single global advance signal stalls every
// stage together under back-pressure.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears valids and data)
//   in_valid   a/b/cin valid this cycle
//   in_ready   adder accepts input this cycle (= global advance)
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   cin        carry in
//   out_valid  sum/cout/ovf valid
//   out_ready  downstream accepts the result
//   sum        (a + b + cin) mod 2^WIDTH
//   cout       carry out of the MSB
//   ovf        signed overflow (carry into MSB XOR carry out of MSB)
// ---------------------------------------------------------------------------
module pipelined_carry_select_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;

    // BLK-bit add with explicit carry-in; bit BLK is the block carry-out.
    function automatic logic [BLK:0] blk_add(input logic [BLK-1:0] x,
                                             input logic [BLK-1:0] y,
                                             input logic           c);
        return {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, c};
    endfunction

    logic adv;

    // Stage registers. Operands travel with the beat so later stages can
    // pick up their slice; res holds the already-resolved low blocks.
    logic [WIDTH-1:0] a_q     [NBLK];
    logic [WIDTH-1:0] b_q     [NBLK];
    logic [WIDTH-1:0] res_q   [NBLK];
    logic             carry_q [NBLK];
    logic             valid_q [NBLK];

    logic [WIDTH-1:0] a_d     [NBLK];
    logic [WIDTH-1:0] b_d     [NBLK];
    logic [WIDTH-1:0] res_d   [NBLK];
    logic             carry_d [NBLK];
    logic             valid_d [NBLK];

    // What each stage sees: stage 0 takes the ports, stage k the regs of k-1.
    logic [WIDTH-1:0] st_a    [NBLK];
    logic [WIDTH-1:0] st_b    [NBLK];
    logic [WIDTH-1:0] st_res  [NBLK];
    logic             st_c    [NBLK];
    logic             st_v    [NBLK];

    logic [BLK:0]     sum0    [NBLK];
    logic [BLK:0]     sum1    [NBLK];
    logic [BLK:0]     sel     [NBLK];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        st_a[0]   = a;
        st_b[0]   = b;
        st_res[0] = '0;
        st_c[0]   = cin;
        st_v[0]   = in_valid;
        for (int k = 1; k < NBLK; k++) begin
            st_a[k]   = a_q[k-1];
            st_b[k]   = b_q[k-1];
            st_res[k] = res_q[k-1];
            st_c[k]   = carry_q[k-1];
            st_v[k]   = valid_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NBLK; k++) begin
            sum0[k]    = blk_add(st_a[k][k*BLK +: BLK], st_b[k][k*BLK +: BLK], 1'b0);
            sum1[k]    = blk_add(st_a[k][k*BLK +: BLK], st_b[k][k*BLK +: BLK], 1'b1);
            sel[k]     = st_c[k] ? sum1[k] : sum0[k];
            a_d[k]     = st_a[k];
            b_d[k]     = st_b[k];
            res_d[k]   = st_res[k];
            res_d[k][k*BLK +: BLK] = sel[k][BLK-1:0];
            carry_d[k] = sel[k][BLK];
            valid_d[k] = st_v[k];
        end
    end

    // All stages load together on adv and hold together when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBLK; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                res_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < NBLK; k++) begin
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                res_q[k]   <= res_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
        end
    end

    assign out_valid = valid_q[NBLK-1];
    assign sum       = res_q[NBLK-1];
    assign cout      = carry_q[NBLK-1];
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign ovf       = a_q[NBLK-1][WIDTH-1] ^ b_q[NBLK-1][WIDTH-1]
                     ^ res_q[NBLK-1][WIDTH-1] ^ carry_q[NBLK-1];

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
module tb_pipelined_carry_select_adder;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_carry_select_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    logic [17:0] exp_q [$];
    logic        hold_v = 1'b0;
    logic [17:0] hold_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer addition, {cout, ovf, sum}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
        logic [16:0] full;
        int          sx, sy, s;
        logic        v;
        full = 17'(x) + 17'(y) + 17'(c);
        sx   = $signed(x);
        sy   = $signed(y);
        s    = sx + sy + int'(c);
        v    = (s > 32767) || (s < -32768);
        return {full[16], v, full[15:0]};
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_data", 64'({cout, ovf, sum}), 64'(hold_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    chk("result", 64'({cout, ovf, sum}), 64'(exp_q.pop_front()));
                    n_out++;
                end
            end
            hold_v    = out_valid && !out_ready;
            hold_data = {cout, ovf, sum};
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, cin));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            cycle();
        end
        if (!acc) chk("send_timeout", 64'(in_ready), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic [15:0] x, input logic [15:0] y, input logic c,
                            input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        lat = 0;
        send(x, y, c);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("latency", 64'(lat), 64'(4));
        chk("dir_sum", 64'(sum), 64'(es));
        chk("dir_cout", 64'(cout), 64'(ec));
        chk("dir_ovf", 64'(ovf), 64'(eo));
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        int  base;
        logic acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        directed(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (3) cycle();

        // Back-to-back beats with a downstream stall in cycles 5-9.
        sent = 0;
        base = n_out;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 9);
            in_valid  = (sent < 8);
            a         = 16'(sent);
            b         = 16'(32'h1000 * sent);
            cin       = 1'b0;
            @(negedge clk);
            if (!out_ready && out_valid) chk("stall_in_ready", 64'(in_ready), 64'(0));
            acc = in_valid && in_ready;
            cycle();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("stall_sent", 64'(sent), 64'(8));
        chk("stall_count", 64'(n_out - base), 64'(8));
        out_ready = 1'b1;

        // Reset while beats are in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(i + 16'h0A00), 16'h0101, 1'b1);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'(0));
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        base = n_out;
        repeat (8) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'(0));
        end
        cycle();

        // Random traffic with random back-pressure.
        sent = 0;
        base = n_out;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (sent >= 2000 && (n_out - base) >= 2000) break;
            in_valid  = (sent < 2000) && ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            @(negedge clk);
            acc = in_valid && in_ready;
            cycle();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("rand_sent", 64'(sent), 64'(2000));
        chk("rand_count", 64'(n_out - base), 64'(2000));
        chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
